uart_tx_fifo: RTL

//  Parametrised UART transmitter with an on-board byte FIFO, configurable frame format and a per-bit baud strobe.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_tx_fifo_sync_fifo.sv | 44 ++++
 rtl/uart_tx_fifo.sv | 106 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared parity encodings, FSM state encoding and width helper for the UART TX path
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  function automatic int width_of(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered flags and a show-ahead read port
//   i_clk, i_reset (sync, high); i_push/i_data write; i_pop consumes o_data; o_full, o_empty
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = width_of(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_d;
  logic push_ok, pop_ok;
  // a push while full is dropped even if a pop happens in the same cycle
  assign push_ok = i_push && !o_full;
  assign pop_ok = i_pop && !o_empty;
  assign cnt_d = cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  assign o_data = mem[rp];
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      o_full <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      wp <= wp + AW'(push_ok);
      rp <= rp + AW'(pop_ok);
      cnt <= cnt_d;
      o_full <= cnt_d == (AW+1)'(DEPTH);
      o_empty <= cnt_d == '0;
    end
  end
  always_ff @(posedge i_clk) if (push_ok) mem[wp] <= i_data;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed UART transmitter with configurable frame format and per-bit baud strobe
//   i_clk, i_reset (sync, high); i_wr/i_data push a word unless o_full
//   o_full, o_empty FIFO flags; o_busy frame on line; o_uart_tx serial out; o_uart_clk bit-start strobe
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BAUD = 104,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_busy,
  output logic                 o_uart_tx,
  output logic                 o_uart_clk
);
  localparam int CW = width_of(CLKS_PER_BAUD);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BAUD - 1);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0] bit_cnt, bit_d;
  logic [DATA_BITS-1:0] sh, sh_d, fifo_data;
  logic par, par_d, tx_d, pop, last;
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) fifo (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_push(i_wr),
    .i_data(i_data),
    .i_pop(pop),
    .o_data(fifo_data),
    .o_full(o_full),
    .o_empty(o_empty)
  );
  assign last = cnt == LAST;
  assign o_busy = state != S_IDLE;
  assign o_uart_clk = state != S_IDLE && cnt == '0;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      o_uart_tx <= 1'b1;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      bit_cnt <= bit_d;
      sh <= sh_d;
      par <= par_d;
      o_uart_tx <= tx_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = last || state == S_IDLE ? '0 : cnt + CW'(1);
    bit_d = bit_cnt;
    sh_d = sh;
    par_d = par;
    pop = 1'b0;
    case (state)
      S_IDLE: if (!o_empty) begin
        pop = 1'b1;
        state_d = S_START;
      end
      S_START: if (last) begin
        state_d = S_DATA;
        bit_d = '0;
      end
      S_DATA: if (last) begin
        sh_d = sh >> 1;
        bit_d = bit_cnt + 4'd1;
        if (bit_cnt == 4'(DATA_BITS - 1)) begin
          state_d = PARITY != PARITY_NONE ? S_PARITY : S_STOP;
          bit_d = '0;
        end
      end
      S_PARITY: if (last) begin
        state_d = S_STOP;
        bit_d = '0;
      end
      S_STOP: if (last) begin
        bit_d = bit_cnt + 4'd1;
        if (bit_cnt == 4'(STOP_BITS - 1)) begin
          state_d = o_empty ? S_IDLE : S_START;
          pop = !o_empty;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // a new frame restarts its own bit timing and latches its parity once
    if (pop) begin
      sh_d = fifo_data;
      par_d = PARITY == PARITY_EVEN ? ^fifo_data : ~^fifo_data;
      cnt_d = '0;
    end
    // the line value for the next cycle, so o_uart_tx comes straight from a flop
    tx_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? sh_d[0] : state_d == S_PARITY ? par_d : 1'b1;
  end
endmodule
